// File: rtl/nfet_array.sv
// ---------------------------------------------------------------------------
// nfet_array
//
// Clocked behavioural model of WIDTH independent NFET pull-down channels, each
// with a resistive pull-up on its drain. A channel's drain is driven low when
// its gate is high and its source is low; otherwise the pull-up lifts it high.
// Rising edges take HIGH_CYCLES clocks, falling edges take LOW_CYCLES clocks.
// With INERTIAL=1, a pulse shorter than the pending delay is swallowed and
// counted as a glitch. With INERTIAL=0, every started transition completes.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset (drain all ones, all IDLE)
//   source     : per-channel FET source level
//   gate       : per-channel FET gate level
//   clr_glitch : synchronous clear of the glitch counter (wins over events)
//   drain      : per-channel registered drain level
//   settled    : high when every channel is IDLE (decoded from state only)
//   glitches   : saturating count of cancelled transitions
// ---------------------------------------------------------------------------
module nfet_array #(
    parameter int WIDTH       = 8,
    parameter int HIGH_CYCLES = 10,
    parameter int LOW_CYCLES  = 1,
    parameter int INERTIAL    = 1,
    parameter int GW          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] source,
    input  logic [WIDTH-1:0] gate,
    input  logic             clr_glitch,
    output logic [WIDTH-1:0] drain,
    output logic             settled,
    output logic [GW-1:0]    glitches
);

    // A single-cycle delay only needs a zero count, so keep at least one bit.
    localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int SW   = $clog2(WIDTH + 1);
    localparam int AW   = ((GW > SW) ? GW : SW) + 1;

    localparam logic [CW-1:0] RISE_LOAD  = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] FALL_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [AW-1:0] GLITCH_MAX = {{(AW-GW){1'b0}}, {GW{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    state_t            state_q [WIDTH];
    state_t            state_d [WIDTH];
    logic [CW-1:0]     count_q [WIDTH];
    logic [CW-1:0]     count_d [WIDTH];
    logic [WIDTH-1:0]  drain_d;
    logic [WIDTH-1:0]  target;
    logic [WIDTH-1:0]  glitch_evt;
    logic [SW-1:0]     event_count;
    logic [AW-1:0]     glitch_sum;
    logic [GW-1:0]     glitches_d;

    // The drain wants to be high unless the FET conducts to a low source.
    assign target = ~gate | source;

    // Per-channel next-state logic. In RISE/FALL the inertial cancel check is
    // evaluated before the count-expired check so a reversal on the final
    // cycle still swallows the pulse.
    always_comb begin
        drain_d    = drain;
        glitch_evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            case (state_q[i])
                IDLE: begin
                    if (target[i] && !drain[i]) begin
                        state_d[i] = RISE;
                        count_d[i] = RISE_LOAD;
                    end else if (!target[i] && drain[i]) begin
                        state_d[i] = FALL;
                        count_d[i] = FALL_LOAD;
                    end
                end
                RISE, FALL: begin
                    if ((INERTIAL != 0) && (target[i] == drain[i])) begin
                        state_d[i]    = IDLE;
                        count_d[i]    = '0;
                        glitch_evt[i] = 1'b1;
                    end else if (count_q[i] == '0) begin
                        state_d[i] = IDLE;
                        drain_d[i] = (state_q[i] == RISE);
                    end else begin
                        count_d[i] = count_q[i] - 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    // Several channels may cancel on the same edge; add them all, saturating.
    always_comb begin
        event_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            event_count = event_count + SW'(glitch_evt[i]);
        end
        glitch_sum = AW'(glitches) + AW'(event_count);
        if (clr_glitch) begin
            glitches_d = '0;
        end else if (glitch_sum > GLITCH_MAX) begin
            glitches_d = '1;
        end else begin
            glitches_d = glitch_sum[GW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain    <= '1;
            glitches <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
        end else begin
            drain    <= drain_d;
            glitches <= glitches_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Decoded only from the state registers, so gate/source never reach it.
    always_comb begin
        settled = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (state_q[i] != IDLE) begin
                settled = 1'b0;
            end
        end
    end

endmodule

// File: doc/nfet_array.md
NFET_ARRAY -- requirements
Module: nfet_array

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8: number of independent NFET channels.
REQ-002 The module SHALL take parameter HIGH_CYCLES, default 10: pull-up rise delay in clock cycles, legal range >= 1.
REQ-003 The module SHALL take parameter LOW_CYCLES, default 1: FET pull-down fall delay in clock cycles, legal range >= 1.
REQ-004 The module SHALL take parameter INERTIAL, default 1: 1 cancels pulses shorter than the delay, 0 lets every started transition complete.
REQ-005 The module SHALL take parameter GW, default 8: width of the glitch counter.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port source, input, WIDTH: per-channel FET source level.
REQ-009 Port gate, input, WIDTH: per-channel FET gate level.
REQ-010 Port clr_glitch, input, 1: synchronous clear of the glitch counter.
REQ-011 Port drain, output, WIDTH: per-channel registered drain level.
REQ-012 Port settled, output, 1: high when every channel is IDLE.
REQ-013 Port glitches, output, GW: saturating count of cancelled transitions.

Function
REQ-014 Per-channel target SHALL be target[i] = ~gate[i] | source[i].
REQ-015 Each channel SHALL hold its own state (IDLE, RISE, FALL) and a down-counter of width $clog2(max(HIGH_CYCLES, LOW_CYCLES)); channels SHALL be fully independent.
REQ-016 IDLE: if the sampled target equals drain, the channel SHALL stay IDLE; if target=1 and drain=0, it SHALL enter RISE with count=HIGH_CYCLES-1; if target=0 and drain=1, it SHALL enter FALL with count=LOW_CYCLES-1.
REQ-017 RISE/FALL: if count=0, the channel SHALL set drain to the destination level (1 for RISE, 0 for FALL) and return to IDLE; otherwise it SHALL decrement count.
REQ-018 Latency: a target change first sampled at edge E SHALL appear on drain after edge E+HIGH_CYCLES (rise) or E+LOW_CYCLES (fall) when the input is held.
REQ-019 INERTIAL=1: in RISE/FALL, if the sampled target equals the current drain, the channel SHALL return to IDLE with drain unchanged and register one glitch event; this check SHALL take priority over count=0.
REQ-020 INERTIAL=0: in RISE/FALL, target reversal SHALL be ignored; the transition SHALL complete on schedule, and the channel SHALL re-evaluate from IDLE on the following edge.
REQ-021 A glitch event SHALL never change drain, and no glitch events SHALL be generated when INERTIAL=0.
REQ-022 glitches SHALL increase by the number of channels that register a glitch event on that edge (0..WIDTH), saturating at 2^GW-1.
REQ-023 If clr_glitch=1, glitches SHALL become 0 on that edge; clear SHALL win over events on the same edge.
REQ-024 settled SHALL be decoded from state registers only: high iff all channels are IDLE, with no combinational path from gate or source.
REQ-025 drain SHALL be driven only by registers and SHALL never glitch between edges.

Reset
REQ-026 On a rising clk edge with rst=1: drain SHALL become all ones, all channels IDLE, all counters 0, glitches 0, settled 1.
REQ-027 rst SHALL override all other activity, including in-flight RISE/FALL transitions, which SHALL be abandoned without counting a glitch.
REQ-028 In the first cycle after reset, any channel whose target is 0 SHALL start FALL per REQ-016.

Verification
REQ-029 Defaults; reset with gate=0x00, source=0x00 -> drain=0xFF, settled=1, glitches=0, and both held indefinitely.
REQ-030 gate[0] 0->1 at edge E, source=0 -> drain[0]=0 after edge E+1 (LOW_CYCLES=1); gate[0] back to 0 at edge F -> drain[0]=1 after edge F+10; settled=0 from E to E+1 and from F to F+10.
REQ-031 INERTIAL=1, drain[3]=0; gate[3] low for 4 cycles then high -> drain[3] stays 0 throughout, glitches=1, settled=1 afterward.
REQ-032 INERTIAL=0, same stimulus as REQ-031 -> drain[3]=1 after edge E+10, then falls 1 edge later after FALL (LOW_CYCLES=1); glitches=0.
REQ-033 8 channels each glitch on the same edge with glitches=250, GW=8 -> glitches=255 (saturate); same edge with clr_glitch=1 -> glitches=0.
REQ-034 rst asserted mid-RISE on channel 5 at count=4 -> after that edge drain=0xFF, settled=1, glitches unchanged at 0; a sampled target of 0 restarts FALL on the next edge.
